// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder/subtractor.
package adder_pkg;

    // Operation select carried alongside each request.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/adder_segment.sv
// W-bit combinational carry-lookahead slice. Every carry is formed directly
// from the generate/propagate terms and the slice carry-in, so the depth of
// the carry logic does not grow as a ripple chain inside the segment.
module adder_segment #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_seg,
    input  logic [W-1:0] b_seg,
    input  logic         c_in,
    output logic [W-1:0] s_seg,
    output logic         c_out,
    output logic         c_msb
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         term;
    logic         pchain;

    assign g = a_seg & b_seg;
    assign p = a_seg ^ b_seg;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in
    always_comb begin
        c      = '0;
        term   = 1'b0;
        pchain = 1'b0;
        c[0]   = c_in;
        for (int i = 0; i < W; i++) begin
            term   = g[i];
            pchain = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term   = term | (pchain & g[j]);
                pchain = pchain & p[j];
            end
            c[i+1] = term | (pchain & c_in);
        end
    end

    assign s_seg = p ^ c[W-1:0];
    assign c_out = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// N-bit adder/subtractor pipelined into STAGES equal segments. Stage k adds
// segment k with the carry registered by stage k-1; finished low segments
// travel forward with the result (deskew), and not-yet-used high operand
// segments travel forward until their stage (skew). The whole pipe stalls
// together when the output is held by the consumer.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  op_e          in_op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / STAGES;

    logic         en;
    logic [N-1:0] b_eff;
    logic         c0;

    // Single global advance enable: a held output freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtraction is a + ~b + 1; the +1 rides in as the stage-0 carry.
    assign b_eff = (in_op == OP_SUB) ? ~b : b;
    assign c0    = (in_op == OP_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * W;   // lowest bit handled by this stage
        localparam int REM = N - LO;  // operand bits still to be added

        logic [REM-1:0]    a_i;
        logic [REM-1:0]    b_i;
        logic              c_i;
        logic              v_i;
        logic [LO+W-1:0]   sum_d;
        logic [W-1:0]      seg_s;
        logic              seg_c;
        logic              seg_msb;
        logic [LO+W-1:0]   sum_r;
        logic              c_r;
        logic              v_r;

        if (k == 0) begin : g_src
            assign a_i   = a;
            assign b_i   = b_eff;
            assign c_i   = c0;
            assign v_i   = in_valid;
            assign sum_d = seg_s;
        end else begin : g_src
            assign a_i   = g_stage[k-1].g_fwd.a_r;
            assign b_i   = g_stage[k-1].g_fwd.b_r;
            assign c_i   = g_stage[k-1].c_r;
            assign v_i   = g_stage[k-1].v_r;
            assign sum_d = {seg_s, g_stage[k-1].sum_r};
        end

        adder_segment #(.W(W)) u_seg (
            .a_seg (a_i[W-1:0]),
            .b_seg (b_i[W-1:0]),
            .c_in  (c_i),
            .s_seg (seg_s),
            .c_out (seg_c),
            .c_msb (seg_msb)
        );

        // Stage register: finished sum bits, segment carry and valid bit.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r   <= 1'b0;
                c_r   <= 1'b0;
                sum_r <= '0;
            end else if (en) begin
                v_r   <= v_i;
                c_r   <= seg_c;
                sum_r <= sum_d;
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_r;

            // Signed overflow from the carries into and out of the MSB.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (en) begin
                    ovf_r <= seg_c ^ seg_msb;
                end
            end
        end else begin : g_fwd
            logic [REM-W-1:0] a_r;
            logic [REM-W-1:0] b_r;
            logic             unused_msb;

            // Only the last stage needs the MSB carry-in.
            assign unused_msb = seg_msb;

            // Carry the untouched upper operand segments to later stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (en) begin
                    a_r <= a_i[REM-1:W];
                    b_r <= b_i[REM-1:W];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_r;
    assign sum       = g_stage[STAGES-1].sum_r;
    assign cout      = g_stage[STAGES-1].c_r;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed corner cases with latency checks,
// reset flush, a random stalled stream against a scoreboard, and depth-1 and
// depth-8 builds.
module tb_pipelined_cla_adder;
    import adder_pkg::*;

    localparam int N = 32;
    localparam int STAGES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    op_e         in_op;
    logic [31:0] a, b, sum;
    logic        cin, cout, ovf;

    logic        in_valid_s1, in_ready_s1, out_valid_s1, out_ready_s1;
    logic [31:0] sum_s1;
    logic        cout_s1, ovf_s1;
    logic        in_valid_s8, in_ready_s8, out_valid_s8, out_ready_s8;
    logic [31:0] sum_s8;
    logic        cout_s8, ovf_s8;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [33:0] sb[$];
    logic        mon_en = 1'b0;
    logic        rnd_mode = 1'b0;
    logic        stall_prev = 1'b0;
    logic [33:0] held = '0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

    pipelined_cla_adder #(.N(N), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s1), .in_ready(in_ready_s1),
        .in_op(in_op), .a(a), .b(b), .cin(cin), .out_valid(out_valid_s1),
        .out_ready(out_ready_s1), .sum(sum_s1), .cout(cout_s1), .ovf(ovf_s1));

    pipelined_cla_adder #(.N(N), .STAGES(8)) dut_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s8), .in_ready(in_ready_s8),
        .in_op(in_op), .a(a), .b(b), .cin(cin), .out_valid(out_valid_s8),
        .out_ready(out_ready_s8), .sum(sum_s8), .cout(cout_s8), .ovf(ovf_s8));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [33:0] model(input op_e op, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci);
        logic [31:0] yy;
        logic        cc;
        logic [32:0] r;
        logic        v;
        yy = (op == OP_SUB) ? ~y : y;
        cc = (op == OP_SUB) ? 1'b1 : ci;
        r  = {1'b0, x} + {1'b0, yy} + {32'd0, cc};
        v  = (x[31] == yy[31]) && (r[31] != x[31]);
        return {v, r[32], r[31:0]};
    endfunction

    // Monitor: scoreboard pops, handshake rule, output hold while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else if (mon_en) begin
            check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (stall_prev)
                check("hold_stable", 64'({out_valid, ovf, cout, sum}), 64'({1'b1, held}));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
                else check("result", 64'({ovf, cout, sum}), 64'(sb.pop_front()));
            end
            stall_prev = out_valid && !out_ready;
            held = {ovf, cout, sum};
        end
    end

    // Present one op; returns #1 after the edge that accepted it.
    task automatic issue(input op_e op, input logic [31:0] x, input logic [31:0] y, input logic ci);
        logic ok;
        ok = 1'b0;
        in_op = op; a = x; b = y; cin = ci; in_valid = 1'b1;
        for (int w = 0; w < 200; w++) begin
            if (rnd_mode) out_ready = ($urandom_range(0, 9) >= 3);
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) check("issue_timeout", 64'(in_ready), 64'(1));
        else sb.push_back(model(op, x, y, ci));
        @(posedge clk); #1;
    endtask

    // Single op into an empty pipe with exact-latency and literal result checks.
    task automatic directed(input string tag, input op_e op, input logic [31:0] x,
                            input logic [31:0] y, input logic ci, input logic [31:0] es,
                            input logic ec, input logic eo);
        out_ready = 1'b1;
        issue(op, x, y, ci);
        in_valid = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            check({tag, "_early"}, 64'(out_valid), 64'(0));
            @(posedge clk); #1;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout_ovf"}, 64'({cout, ovf}), 64'({ec, eo}));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_op = OP_ADD;
        a = '0; b = '0; cin = 1'b0;
        in_valid_s1 = 1'b0; out_ready_s1 = 1'b1; in_valid_s8 = 1'b0; out_ready_s8 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out", 64'({out_valid, ovf, cout, sum}), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_s1_s8", 64'({out_valid_s1, out_valid_s8, sum_s1, sum_s8}), 64'(0));
        mon_en = 1'b1;

        directed("add_ripple", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_neg", OP_SUB, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("add_cin", OP_ADD, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0);

        // Depth-1 and depth-8 builds
        in_op = OP_ADD; a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0;
        check("s1_s8_in_ready", 64'({in_ready_s1, in_ready_s8}), 64'(2'b11));
        in_valid_s1 = 1'b1; in_valid_s8 = 1'b1;
        @(posedge clk); #1;
        in_valid_s1 = 1'b0; in_valid_s8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) begin
                check("s1_valid", 64'(out_valid_s1), 64'(1));
                check("s1_sum", 64'(sum_s1), 64'(32'h0001_0000));
            end else check("s1_bubble", 64'(out_valid_s1), 64'(0));
            if (i == 8) begin
                check("s8_valid", 64'(out_valid_s8), 64'(1));
                check("s8_sum", 64'(sum_s8), 64'(32'h0001_0000));
            end else check("s8_early", 64'(out_valid_s8), 64'(0));
            @(posedge clk); #1;
        end

        // Three ops in flight, then reset with a competing input held valid
        out_ready = 1'b1;
        issue(OP_ADD, 32'd1, 32'd2, 1'b0);
        issue(OP_SUB, 32'd9, 32'd3, 1'b0);
        issue(OP_ADD, 32'hDEAD_0000, 32'h0000_BEEF, 1'b1);
        in_op = OP_ADD; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("rst_flush_valid", 64'(out_valid), 64'(0));
        check("rst_flush_sum", 64'({ovf, cout, sum}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        repeat (6) begin
            check("rst_no_emerge", 64'(out_valid), 64'(0));
            @(posedge clk); #1;
        end
        directed("post_rst", OP_ADD, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 32'h1010_1011, 1'b0, 1'b0);

        // Random back-to-back stream with ~30% backpressure
        rnd_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] x, y;
            x = $urandom; y = $urandom;
            if (n % 50 == 0) begin x = 32'hFFFF_FFFF; y = 32'h0000_0001; end
            if (n % 50 == 25) begin x = 32'h8000_0000; y = 32'h8000_0000; end
            issue(($urandom_range(0, 1) == 1) ? OP_SUB : OP_ADD, x, y, 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        for (int w = 0; w < 2000 && sb.size() != 0; w++) begin
            out_ready = ($urandom_range(0, 9) >= 3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        rnd_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- N-bit adder/subtractor split into STAGES equal segments, with one registered segment add per pipeline stage.
- Throughput is one operation per clock. The carry is registered between segments, operands are skewed on entry and results deskewed on exit.
- Valid/ready handshake on input and output, with full-pipeline stall on output backpressure.
- Used in the datapath wherever N exceeds the single-cycle carry-chain timing budget.

Parameters:
- N, 32, operand/result width.
- STAGES, 4, pipeline depth. Must divide N evenly. Segment width W = N/STAGES. STAGES=1 is legal.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input operation valid.
- in_ready  output  1  block can accept an input this cycle.
- in_op  input  1  adder_pkg::op_e; OP_ADD=0, OP_SUB=1.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in; used for OP_ADD only.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  N  result.
- cout  output  1  carry out of the MSB. For OP_SUB, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- **Arithmetic**
  - OP_ADD: {cout,sum} = a + b + cin.
  - OP_SUB: {cout,sum} = a + ~b + 1; cin is ignored.
  - ovf = carry into MSB XOR carry out of MSB.
  - Results are exact modulo 2^N.
- **Pipeline**
  - Stage k (0..STAGES-1) adds segment k (bits k*W+W-1 : k*W) using the registered carry from stage k-1. Stage 0 uses cin, or 1 for OP_SUB.
  - Each stage register holds: finished sum segments 0..k, the segment carry, untouched operand segments k+1..STAGES-1 (b already inverted for SUB), and a valid bit.
  - The last stage also captures the MSB carry-in to form ovf.
- **Latency**: an input accepted at edge t (in_valid && in_ready) appears on sum/cout/ovf with out_valid=1 at edge t+STAGES, provided there is no stall.
- **Flow control**
  - en = !out_valid || out_ready; in_ready = en (combinational).
  - When en=0, every stage register holds, including valid bits and data.
  - When en=1, all stages advance. A stage with no valid input loads valid=0.
  - Bubbles propagate; they are never compressed.
  - Outputs are stable while out_valid && !out_ready. Order is strictly FIFO; no loss, no duplication.
- **Reset**
  - On rst, all valid bits, sum, cout and ovf clear to 0 at the next edge. in_ready is 1 on the following cycle.
  - Reset mid-operation discards all in-flight operations; none emerges afterwards.
  - rst has priority over the handshake.
- **Boundaries**
  - in_valid && out_valid && out_ready in the same cycle: accept and emit simultaneously.
  - in_valid while stalled: not accepted; the source must hold its inputs.
  - STAGES=1: single register stage, latency 1.

Decomposition:
- **adder_pkg**: typedef enum logic {OP_ADD, OP_SUB} op_e.
- **adder_segment**: sub-module, W-bit combinational carry-lookahead slice with generate/propagate logic.
  - Inputs: a_seg, b_seg, c_in.
  - Outputs: s_seg, c_out, c_msb (the carry into its top bit).
  - Instantiated STAGES times in a generate loop.
- Stage registers are a generate array in the top module. No FSM is needed beyond the valid bits.

Test Plan (N=32, STAGES=4 unless noted):
- ADD 0xFFFFFFFF + 0x00000001, cin=0, out_ready=1 -> 4 cycles later: sum=0x00000000, cout=1, ovf=0 (carry ripples through all stages).
- SUB 5 - 7, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. SUB 0x80000000 - 1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- ADD 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, ovf=1.
- Stream 1000 random ADD/SUB ops back-to-back, out_ready randomly low 30% -> results match a scoreboard in order. Outputs are held stable while stalled; in_ready=0 whenever out_valid && !out_ready.
- Three ops in flight, assert rst for 1 cycle -> out_valid=0, sum=0 next cycle; none of the three appears; a new op issued after reset is correct with latency 4.
- STAGES=1 and STAGES=8 builds: ADD 0x0000FFFF + 0x00000001 -> sum=0x00010000 with latency 1 and 8 respectively.
